// File: rtl/intersection_pkg.sv
// intersection_pkg: shared state encoding and phase counter width for the intersection controller
package intersection_pkg;
  localparam int CW = 5;
  typedef enum logic [2:0] {
    AR_NS = 3'd0,
    NS_G  = 3'd1,
    NS_Y  = 3'd2,
    AR_EW = 3'd3,
    EW_G  = 3'd4,
    EW_Y  = 3'd5
  } state_e;
endpackage

// File: rtl/intersection_if.sv
// intersection_if: call/preempt inputs and lamp/debug outputs of the intersection controller
interface intersection_if;
  logic       req_ns, req_ew, emerg, emerg_dir;
  logic       ns_r, ns_y, ns_g, ew_r, ew_y, ew_g;
  logic [2:0] phase;
  modport master (
    output req_ns, req_ew, emerg, emerg_dir,
    input  ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, phase
  );
  modport slave (
    input  req_ns, req_ew, emerg, emerg_dir,
    output ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, phase
  );
endinterface

// File: rtl/phase_timer.sv
// phase_timer: saturating phase counter with clear, flags when the current phase duration is reached
module phase_timer
  import intersection_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [CW-1:0] dur,
  output logic          hit
);
  logic [CW-1:0] count;
  always_ff @(posedge clk)
    if (rst || clr) count <= '0;
    else if (count != '1) count <= count + 1'b1;
  assign hit = count >= dur - 1'b1;
endmodule

// File: rtl/intersection_ctrl.sv
// intersection_ctrl: two-way signal controller with call latches; EMERG_PREEMPT_EN enables emergency preemption
module intersection_ctrl
  import intersection_pkg::*;
#(
  parameter int MIN_G   = 4,
  parameter int Y_TIME  = 3,
  parameter int AR_TIME = 2
) (
  input logic           clk,
  input logic           rst,
  intersection_if.slave bus
);
  state_e        state, next;
  logic          call_ns, call_ew, hit, hold, clr, em_ns, em_ew;
  logic [CW-1:0] dur;
`ifdef EMERG_PREEMPT_EN
  assign em_ns = bus.emerg && !bus.emerg_dir;
  assign em_ew = bus.emerg && bus.emerg_dir;
`else
  logic unused_emerg;
  assign em_ns = 1'b0;
  assign em_ew = 1'b0;
  assign unused_emerg = bus.emerg ^ bus.emerg_dir;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state   <= AR_NS;
      call_ns <= 1'b0;
      call_ew <= 1'b0;
    end else begin
      state   <= next;
      call_ns <= (next == NS_G && state != NS_G) ? 1'b0 : call_ns | (bus.req_ns && state != NS_G);
      call_ew <= (next == EW_G && state != EW_G) ? 1'b0 : call_ew | (bus.req_ew && state != EW_G);
    end
  // A preempted target green keeps its timer cleared so normal timing restarts on release
  always_comb begin
    next = state;
    hold = 1'b0;
    dur  = (state == AR_NS || state == AR_EW) ? CW'(AR_TIME) :
           (state == NS_Y || state == EW_Y) ? CW'(Y_TIME) : CW'(MIN_G);
    case (state)
      AR_NS: next = hit ? NS_G : AR_NS;
      NS_G: begin
        hold = em_ns;
        next = (em_ew || (!em_ns && hit && call_ew)) ? NS_Y : NS_G;
      end
      NS_Y:  next = hit ? AR_EW : NS_Y;
      AR_EW: next = hit ? EW_G : AR_EW;
      EW_G: begin
        hold = em_ew;
        next = (em_ns || (!em_ew && hit && call_ns)) ? EW_Y : EW_G;
      end
      EW_Y:  next = hit ? AR_NS : EW_Y;
      default: next = AR_NS;
    endcase
    clr = hold || next != state;
  end
  phase_timer u_timer (.clk(clk), .rst(rst), .clr(clr), .dur(dur), .hit(hit));
  assign bus.ns_g  = state == NS_G;
  assign bus.ns_y  = state == NS_Y;
  assign bus.ns_r  = state != NS_G && state != NS_Y;
  assign bus.ew_g  = state == EW_G;
  assign bus.ew_y  = state == EW_Y;
  assign bus.ew_r  = state != EW_G && state != EW_Y;
  assign bus.phase = state;
endmodule

// File: tb/tb_intersection_ctrl.sv
// tb_intersection_ctrl: directed scenarios plus randomized calls/preempts checked against a direction/phase-kind model
module tb_intersection_ctrl;
  import intersection_pkg::*;
  localparam int MIN_G = 4, Y_TIME = 3, AR_TIME = 2;
`ifdef EMERG_PREEMPT_EN
  localparam bit EM = 1'b1;
`else
  localparam bit EM = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  intersection_if bus ();
  intersection_ctrl #(.MIN_G(MIN_G), .Y_TIME(Y_TIME), .AR_TIME(AR_TIME)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int m_dir, m_kind, m_t;
  bit [1:0] m_call;
  state_e tbl [2][3] = '{'{AR_NS, NS_G, NS_Y}, '{AR_EW, EW_G, EW_Y}};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  // kind: 0 all-red before green of m_dir, 1 green, 2 yellow
  task automatic model_update();
    bit r [2];
    bit em;
    int tgt, nd, nk, nt;
    bit [1:0] nc;
    r[0] = bus.req_ns;
    r[1] = bus.req_ew;
    em  = EM && bus.emerg;
    tgt = int'(bus.emerg_dir);
    if (rst) begin
      m_dir = 0; m_kind = 0; m_t = 0; m_call = 2'b00;
      return;
    end
    nd = m_dir; nk = m_kind; nt = m_t < 31 ? m_t + 1 : 31; nc = m_call;
    for (int d = 0; d < 2; d++) if (r[d] && !(m_kind == 1 && m_dir == d)) nc[d] = 1'b1;
    if (m_kind == 0 && m_t == AR_TIME - 1) begin
      nk = 1; nt = 0; nc[m_dir] = 1'b0;
    end else if (m_kind == 1) begin
      if (em && tgt == m_dir) nt = 0;
      else if (em || (m_t >= MIN_G - 1 && m_call[1-m_dir])) begin nk = 2; nt = 0; end
    end else if (m_kind == 2 && m_t == Y_TIME - 1) begin
      nk = 0; nd = 1 - m_dir; nt = 0;
    end
    m_dir = nd; m_kind = nk; m_t = nt; m_call = nc;
  endtask
  task automatic step();
    logic [5:0] el;
    @(posedge clk);
    model_update();
    #1;
    el = {!(m_dir == 0 && m_kind != 0), m_dir == 0 && m_kind == 2, m_dir == 0 && m_kind == 1,
          !(m_dir == 1 && m_kind != 0), m_dir == 1 && m_kind == 2, m_dir == 1 && m_kind == 1};
    check("phase", bus.phase, tbl[m_dir][m_kind]);
    check("lamps", {bus.ns_r, bus.ns_y, bus.ns_g, bus.ew_r, bus.ew_y, bus.ew_g}, el);
    check("ns_onehot", $onehot({bus.ns_r, bus.ns_y, bus.ns_g}), 1);
    check("ew_onehot", $onehot({bus.ew_r, bus.ew_y, bus.ew_g}), 1);
    check("conflict", !bus.ns_r && !bus.ew_r, 0);
  endtask
  task automatic run_len(input state_e p, output int n);
    n = 0;
    while (bus.phase == p && n < 200) begin n++; step(); end
  endtask
  task automatic wait_phase(input state_e p, input int lim, output bit ok);
    int n = 0;
    while (bus.phase != p && n < lim) begin n++; step(); end
    ok = bus.phase == p;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask
  initial begin
    int n;
    bit ok;
    bus.req_ns = 0; bus.req_ew = 0; bus.emerg = 0; bus.emerg_dir = 0;
    do_reset();
    check("rst_phase", bus.phase, AR_NS);
    check("rst_red", {bus.ns_r, bus.ew_r, bus.ns_g, bus.ew_g}, 4'b1100);
    step();
    check("ar_2nd", bus.phase, AR_NS);
    step();
    check("ns_first", bus.phase, NS_G);
    repeat (50) step();
    check("ns_rest50", bus.phase, NS_G);
    do_reset(); step(); step();
    bus.req_ew = 1; step(); bus.req_ew = 0;
    run_len(NS_G, n);   check("ns_g_len", n + 1, 4);
    run_len(NS_Y, n);   check("ns_y_len", n, 3);
    run_len(AR_EW, n);  check("ar_ew_len", n, 2);
    check("ew_green", bus.phase, EW_G);
    repeat (10) step();
    check("ew_rest", bus.phase, EW_G);
    do_reset(); step(); step();
    bus.req_ew = 1; step(); bus.req_ew = 0;
    wait_phase(NS_Y, 20, ok); check("reach_ns_y", ok, 1);
    step();
    rst = 1; step(); rst = 0;
    check("rst_in_y", bus.phase, AR_NS);
    step(); check("rst_y_ar2", bus.phase, AR_NS);
    step(); check("rst_y_ns", bus.phase, NS_G);
    do_reset();
    bus.req_ns = 1; bus.req_ew = 1; step(); bus.req_ns = 0; bus.req_ew = 0;
    step(); check("both_ns", bus.phase, NS_G);
    run_len(NS_G, n);   check("both_ns_len", n, 4);
    run_len(NS_Y, n);   check("both_y_len", n, 3);
    run_len(AR_EW, n);  check("both_ar_len", n, 2);
    check("both_ew", bus.phase, EW_G);
    repeat (10) step();
    check("both_ew_rest", bus.phase, EW_G);
    bus.req_ns = 1; step(); bus.req_ns = 0;
    wait_phase(EW_Y, 5, ok); check("ew_exit", ok, 1);
`ifdef EMERG_PREEMPT_EN
    do_reset(); step(); step();
    bus.req_ew = 1; step(); bus.req_ew = 0;
    wait_phase(EW_G, 30, ok); check("reach_ew_g", ok, 1);
    bus.emerg = 1; bus.emerg_dir = 0;
    step(); check("em_ew_y", bus.phase, EW_Y);
    run_len(EW_Y, n);   check("em_y_len", n, 3);
    run_len(AR_NS, n);  check("em_ar_len", n, 2);
    check("em_ns_g", bus.phase, NS_G);
    bus.req_ew = 1; step(); bus.req_ew = 0;
    repeat (20) step();
    check("em_hold", bus.phase, NS_G);
    bus.emerg = 0;
    wait_phase(NS_Y, 10, ok); check("em_release", ok, 1);
`endif
    for (int i = 0; i < 4000; i++) begin
      rst = $urandom_range(0, 299) == 0;
      bus.req_ns = $urandom_range(0, 7) == 0;
      bus.req_ew = $urandom_range(0, 7) == 0;
      if ($urandom_range(0, 49) == 0) bus.emerg = ~bus.emerg;
      if ($urandom_range(0, 99) == 0) bus.emerg_dir = ~bus.emerg_dir;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/intersection_ctrl.md
INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 Parameter MIN_G, default 4: minimum green length in cycles, legal range 1..31.
REQ-002 Parameter Y_TIME, default 3: yellow length in cycles, legal range 1..31.
REQ-003 Parameter AR_TIME, default 2: all-red clearance length in cycles, legal range 1..31.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_ns  input  1  north-south call (vehicle/pedestrian); may be a single-cycle pulse.
REQ-007 req_ew  input  1  east-west call; may be a single-cycle pulse.
REQ-008 emerg  input  1  emergency preempt request; level-sensitive.
REQ-009 emerg_dir  input  1  preempt target direction: 0 = NS, 1 = EW.
REQ-010 ns_r, ns_y, ns_g  output  1 each  NS lamps; exactly one high at all times.
REQ-011 ew_r, ew_y, ew_g  output  1 each  EW lamps; exactly one high at all times.
REQ-012 phase  output  3  current state encoding, for debug.

Function
REQ-013 States SHALL be AR_NS (all-red before NS green), NS_G, NS_Y, AR_EW (all-red before EW green), EW_G, EW_Y.
REQ-014 Lamp outputs SHALL be a combinational decode of the state register only: red in every state except its own direction's G/Y.
REQ-015 A 5-bit phase counter SHALL clear on every state change and increment each cycle; it saturates at 31 and never wraps.
REQ-016 AR_NS -> NS_G and AR_EW -> EW_G SHALL occur when count == AR_TIME-1, so each all-red phase lasts exactly AR_TIME cycles.
REQ-017 NS_Y -> AR_EW and EW_Y -> AR_NS SHALL occur when count == Y_TIME-1.
REQ-018 NS_G -> NS_Y SHALL occur when count >= MIN_G-1 and the EW call latch is set; EW_G -> EW_Y is symmetric.
REQ-019 With no opposing call, green SHALL rest indefinitely.
REQ-020 Each direction SHALL have a call latch, set by its req input in any cycle.
REQ-021 A call latch SHALL clear on entry to that direction's green.
REQ-022 A request asserted during its own green SHALL be ignored, and the latch SHALL not set.
REQ-023 Simultaneous req_ns and req_ew SHALL both latch; service order follows the fixed cycle, with no starvation.
REQ-024 A request arriving in the same cycle as a green-exit decision SHALL take effect from the next cycle.

Reset
REQ-025 When rst is high at a clock edge, state SHALL become AR_NS, count 0, both latches 0.
REQ-026 Outputs one cycle after reset SHALL be all red, phase = AR_NS.
REQ-027 Reset asserted mid-phase, including yellow, SHALL abort immediately with no completion of the yellow.

Configuration
REQ-028 Macro EMERG_PREEMPT_EN SHALL enable preemption.
REQ-029 When defined and emerg = 1: a green in the non-target direction SHALL go to its yellow immediately, ignoring MIN_G.
REQ-030 When defined and emerg = 1: a yellow or all-red in progress SHALL complete normally.
REQ-031 When defined: the target green SHALL hold while emerg = 1; on release, normal rules resume with the count cleared.
REQ-032 When defined: emerg_dir changing while emerg = 1 SHALL be handled as a new preempt via the normal yellow/all-red path.
REQ-033 When EMERG_PREEMPT_EN is undefined, emerg and emerg_dir ports SHALL remain present and be ignored.

Structure
REQ-034 Package intersection_pkg SHALL hold the state enum/encodings and the 5-bit counter width constant.
REQ-035 Sub-module phase_timer SHALL contain the counter (clear, increment, saturate, compare against a duration input), instantiated once.

Verification
REQ-036 Release rst -> all red for 2 cycles, then NS green; with no requests, NS green held 50 cycles.
REQ-037 Single-cycle req_ew pulse 1 cycle into NS green -> NS green lasts 4 cycles, NS yellow 3, all-red 2, then EW green; EW latch reads 0.
REQ-038 req_ns and req_ew pulsed together during AR_NS -> NS green 4 cycles, then EW green; EW green ends after 4 cycles only if req_ns is re-pulsed.
REQ-039 rst asserted during the 2nd cycle of NS yellow -> all red next cycle, then NS green after 2 cycles.
REQ-040 EMERG_PREEMPT_EN defined, emerg = 1, emerg_dir = 0 during EW green count 0 -> EW yellow next cycle, 3 yellow, 2 all-red, NS green held until emerg drops.
REQ-041 Every cycle of every test -> assertion: never both directions non-red, and exactly one lamp per direction.
